// File: rtl/kugelblitz_cfg_arbiter_pkg.sv
// kugelblitz_cfg_arbiter_pkg
// Definitions shared by the kugelblitz config-path blocks. It provides the
// arbiter FSM state encoding, the default drop-counter width, and a helper that
// sizes an index field. The index field is always at least 1 bit wide.
package kugelblitz_cfg_arbiter_pkg;

  typedef enum logic {
    CFG_IDLE  = 1'b0,
    CFG_ISSUE = 1'b1
  } cfg_arb_state_e;

  localparam int KG_DROP_CNT_WIDTH = 16;

  function automatic int sel_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/kugelblitz_rr_select.sv
// kugelblitz_rr_select
// Combinational round-robin picker. It scans the request vector starting one
// past last_grant and wraps modulo REQ_COUNT. It returns the first requester
// found.
//
// Ports:
//   req        in   REQ_COUNT   request vector
//   last_grant in   SEL_WIDTH   index granted most recently
//   grant      out  SEL_WIDTH   selected index (0 when nothing requests)
//   any_valid  out  1           at least one request present
module kugelblitz_rr_select #(
  parameter int REQ_COUNT = 2,
  parameter int SEL_WIDTH = 1
) (
  input  logic [REQ_COUNT-1:0] req,
  input  logic [SEL_WIDTH-1:0] last_grant,
  output logic [SEL_WIDTH-1:0] grant,
  output logic                 any_valid
);

  logic [2*REQ_COUNT-1:0] req_dbl;
  logic [REQ_COUNT-1:0]   req_rot;
  int                     start;

  // Rotate the request vector so the scan origin sits at bit 0. The vector is
  // doubled first so the wrap-around bits come along with the shift.
  always_comb begin
    start     = (int'(last_grant) + 1) % REQ_COUNT;
    req_dbl   = {req, req};
    req_rot   = REQ_COUNT'(req_dbl >> start);
    grant     = '0;
    any_valid = 1'b0;
    // Walk from the far end so the lowest rotated position wins.
    for (int k = REQ_COUNT - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        grant     = SEL_WIDTH'((start + k) % REQ_COUNT);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kugelblitz_cfg_arbiter.sv
// kugelblitz_cfg_arbiter
// Shares the single configuration write port of the kugelblitz offload engine
// among PORT_COUNT register-file requesters, in the kg_axil_clk domain.
//
// Each requester owns a one-entry holding register. Pending entries are
// granted round-robin onto a valid/ready master channel. Every grant is
// followed by a one-cycle IDLE bubble.
//
// Optional build macro: KUGELBLITZ_CFG_ARB_STATS_EN adds grant_count, a
// wrapping 32-bit handshake counter for each port.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   s_cfg_addr     in   PORT_COUNT*ADDR_WIDTH       per-port write address
//   s_cfg_data     in   PORT_COUNT*DATA_WIDTH       per-port write data
//   s_cfg_valid    in   PORT_COUNT                  single-cycle request strobes
//   s_cfg_pending  out  PORT_COUNT                  holding register occupied
//   s_cfg_done     out  PORT_COUNT                  pulse after downstream accept
//   m_cfg_addr     out  ADDR_WIDTH                  granted address
//   m_cfg_data     out  DATA_WIDTH                  granted data
//   m_cfg_port     out  PORT_SEL_WIDTH              granted port index
//   m_cfg_valid    out  1                           master valid
//   m_cfg_ready    in   1                           master ready
//   drop_count     out  PORT_COUNT*DROP_CNT_WIDTH   saturating drop counters
//   grant_count    out  PORT_COUNT*32               (stats build only)
//
// state     | meaning
// ----------+------------------------------------------------------------
// CFG_IDLE  | nothing on the master channel; pick the next pending port
// CFG_ISSUE | m_cfg_* held stable with valid=1 until m_cfg_ready
module kugelblitz_cfg_arbiter
  import kugelblitz_cfg_arbiter_pkg::*;
#(
  parameter int PORT_COUNT     = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int DROP_CNT_WIDTH = KG_DROP_CNT_WIDTH,
  parameter int PORT_SEL_WIDTH = sel_width(PORT_COUNT)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PORT_COUNT*ADDR_WIDTH-1:0]   s_cfg_addr,
  input  logic [PORT_COUNT*DATA_WIDTH-1:0]   s_cfg_data,
  input  logic [PORT_COUNT-1:0]              s_cfg_valid,
  output logic [PORT_COUNT-1:0]              s_cfg_pending,
  output logic [PORT_COUNT-1:0]              s_cfg_done,
  output logic [ADDR_WIDTH-1:0]              m_cfg_addr,
  output logic [DATA_WIDTH-1:0]              m_cfg_data,
  output logic [PORT_SEL_WIDTH-1:0]          m_cfg_port,
  output logic                               m_cfg_valid,
  input  logic                               m_cfg_ready,
  output logic [PORT_COUNT*DROP_CNT_WIDTH-1:0] drop_count
`ifdef KUGELBLITZ_CFG_ARB_STATS_EN
  ,
  output logic [PORT_COUNT*32-1:0]           grant_count
`endif
);

  cfg_arb_state_e            state, state_nxt;
  logic [ADDR_WIDTH-1:0]     hold_addr [PORT_COUNT];
  logic [DATA_WIDTH-1:0]     hold_data [PORT_COUNT];
  logic [PORT_COUNT-1:0]     pending;
  logic [PORT_COUNT-1:0]     rel_vec;
  logic [PORT_SEL_WIDTH-1:0] last_grant;
  logic [PORT_SEL_WIDTH-1:0] pick;
  logic                      pick_any;
  logic                      load_m;
  logic                      handshake;

  assign s_cfg_pending = pending;

  kugelblitz_rr_select #(
    .REQ_COUNT (PORT_COUNT),
    .SEL_WIDTH (PORT_SEL_WIDTH)
  ) u_rr_select (
    .req        (pending),
    .last_grant (last_grant),
    .grant      (pick),
    .any_valid  (pick_any)
  );

  always_comb begin
    state_nxt = state;
    load_m    = 1'b0;
    handshake = 1'b0;
    case (state)
      CFG_IDLE: begin
        if (pick_any) begin
          load_m    = 1'b1;
          state_nxt = CFG_ISSUE;
        end
      end
      CFG_ISSUE: begin
        // Ready only matters while valid is up.
        if (m_cfg_valid && m_cfg_ready) begin
          handshake = 1'b1;
          state_nxt = CFG_IDLE;
        end
      end
      default: state_nxt = CFG_IDLE;
    endcase
  end

  // last_grant resets to the top index so that port 0 wins the first scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CFG_IDLE;
      last_grant  <= PORT_SEL_WIDTH'(PORT_COUNT - 1);
      m_cfg_addr  <= '0;
      m_cfg_data  <= '0;
      m_cfg_port  <= '0;
      m_cfg_valid <= 1'b0;
      s_cfg_done  <= '0;
    end else begin
      state      <= state_nxt;
      s_cfg_done <= rel_vec;
      if (load_m) begin
        m_cfg_addr  <= hold_addr[pick];
        m_cfg_data  <= hold_data[pick];
        m_cfg_port  <= pick;
        m_cfg_valid <= 1'b1;
      end else if (handshake) begin
        m_cfg_valid <= 1'b0;
        last_grant  <= m_cfg_port;
      end
    end
  end

  for (genvar n = 0; n < PORT_COUNT; n++) begin : g_port
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      pend_q;
    logic [DROP_CNT_WIDTH-1:0] drop_q;

    assign rel_vec[n]   = handshake && (m_cfg_port == PORT_SEL_WIDTH'(n));
    assign hold_addr[n] = addr_q;
    assign hold_data[n] = data_q;
    assign pending[n]   = pend_q;
    assign drop_count[n*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] = drop_q;

    // A strobe that lands in the same cycle as the release of this port
    // refills the holding register. It is not counted as a drop.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        addr_q <= '0;
        data_q <= '0;
        pend_q <= 1'b0;
        drop_q <= '0;
      end else if (s_cfg_valid[n]) begin
        if (!pend_q || rel_vec[n]) begin
          addr_q <= s_cfg_addr[n*ADDR_WIDTH +: ADDR_WIDTH];
          data_q <= s_cfg_data[n*DATA_WIDTH +: DATA_WIDTH];
          pend_q <= 1'b1;
        end else if (drop_q != '1) begin
          drop_q <= drop_q + DROP_CNT_WIDTH'(1);
        end
      end else if (rel_vec[n]) begin
        pend_q <= 1'b0;
      end
    end

`ifdef KUGELBLITZ_CFG_ARB_STATS_EN
    logic [31:0] gcnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        gcnt_q <= '0;
      end else if (rel_vec[n]) begin
        gcnt_q <= gcnt_q + 32'd1;
      end
    end

    assign grant_count[n*32 +: 32] = gcnt_q;
`else
    // No per-port grant statistics in this build.
`endif
  end

endmodule

// File: doc/kugelblitz_cfg_arbiter.md
Name: kugelblitz_cfg_arbiter

Overview:
- Shares one configuration write port into the kugelblitz offload engine between PORT_COUNT per-port AXI-lite register files (kg_address/kg_data/valid producers).
- Each requester gets a one-entry holding register, with round-robin grant onto a valid/ready master channel.
- Reports per-port commit completion and saturating drop counts.
- Sits between the per-port axil_kg_regfile instances and the engine's config memory, in the kg_axil_clk domain.

Parameters:
- PORT_COUNT, 2, number of requesters (1..8).
- ADDR_WIDTH, 32, config address width.
- DATA_WIDTH, 32, config data width.
- DROP_CNT_WIDTH, 16, width of each per-port drop counter.
- PORT_SEL_WIDTH, $clog2(PORT_COUNT) (min 1), width of granted port index.

Ports:
- clk  in  1  config clock (kg_axil_clk domain).
- rst  in  1  asynchronous, active-high reset.
- s_cfg_addr  in  PORT_COUNT*ADDR_WIDTH  per-port write address.
- s_cfg_data  in  PORT_COUNT*DATA_WIDTH  per-port write data.
- s_cfg_valid  in  PORT_COUNT  single-cycle request strobe per port.
- s_cfg_pending  out  PORT_COUNT  holding register n occupied.
- s_cfg_done  out  PORT_COUNT  one-cycle pulse when port n's write is accepted downstream.
- m_cfg_addr  out  ADDR_WIDTH  granted address.
- m_cfg_data  out  DATA_WIDTH  granted data.
- m_cfg_port  out  PORT_SEL_WIDTH  index of granted port.
- m_cfg_valid  out  1  master request valid.
- m_cfg_ready  in  1  downstream accept.
- drop_count  out  PORT_COUNT*DROP_CNT_WIDTH  per-port saturating count of discarded strobes.

Behaviour:
- Reset, asynchronous: all outputs 0; holding registers empty; FSM in IDLE; last_grant = PORT_COUNT-1 so port 0 wins first.
- Capture:
  - s_cfg_valid[n]=1 with holding[n] empty → addr/data latched on that edge; s_cfg_pending[n]=1 next cycle.
  - Strobe while holding[n] full and not released that cycle → strobe discarded, drop_count[n] += 1, saturating at all-ones.
  - Strobe in the same cycle holding[n] is released (m handshake on port n) → new request latched, pending stays 1, no drop.
- FSM:
  - IDLE: if any pending, select first pending port scanning from last_grant+1 modulo PORT_COUNT. Register m_cfg_addr/data/port from that holding register; m_cfg_valid=1 next cycle; go ISSUE. No pending → stay IDLE, m_cfg_valid=0.
  - ISSUE: m_cfg_* held stable while m_cfg_valid=1 and m_cfg_ready=0 (AXI-stream rules; valid never drops without handshake). On m_cfg_valid & m_cfg_ready: clear pending[g], pulse s_cfg_done[g] next cycle, last_grant=g, m_cfg_valid=0, go IDLE.
- Latency: strobe at cycle 0 → pending at 1 → m_cfg_valid at 2 (ready tied high: handshake at 2, done pulse at 3).
- Throughput: one write per 2 cycles (mandatory IDLE bubble).
- Fairness: no port granted twice while another port stays pending.
- m_cfg_ready is ignored when m_cfg_valid=0.
- Reset mid-ISSUE: transfer abandoned, no done pulse, drop counters cleared.
- PORT_COUNT=1: arbitration degenerates; m_cfg_port constant 0.

Optional Feature:
- Macro KUGELBLITZ_CFG_ARB_STATS_EN.
- Defined: adds output grant_count, PORT_COUNT*32, one wrapping counter per port, incremented on each m handshake for that port, reset to 0.
- Undefined: port and counters absent; all other behaviour identical.

Decomposition:
- Shared header/package: FSM state encodings (IDLE=1'b0, ISSUE=1'b1) and the default DROP_CNT_WIDTH constant, reused by other kugelblitz config blocks.
- One natural sub-module: kugelblitz_rr_select, a combinational round-robin picker.
  - Inputs: request vector, last_grant.
  - Outputs: grant index, any_valid.
  - Reusable for the planned rx/tx offload schedulers.

Test Plan:
- Single request: port0 strobe addr=0x10 data=0xA5A5A5A5, ready=1 → m_cfg_valid at cycle 2 with port=0, addr=0x10, data=0xA5A5A5A5; s_cfg_done[0] at cycle 3; pending[0] clears.
- Simultaneous: ports 0 and 1 strobe same cycle, ready=1 → port0 granted first, port1 two cycles later; repeat → port0 then port1 again (round-robin rotation via last_grant).
- Backpressure: ready=0 for 5 cycles during ISSUE → m_cfg_addr/data/port/valid stable all 5 cycles; handshake on 6th; exactly one done pulse.
- Overflow: port1 strobes 3 times while ready=0 → first held, drop_count[1]=2; later, 0xFFFF drops saturate at 0xFFFF.
- Release+refill: port0 strobe in exact handshake cycle of its previous write → no drop; second write issued after bubble.
- Reset during ISSUE with ready=0 → all outputs 0 immediately; no done pulse; next request after reset granted to port 0.
